ksa_pipe_alu: RTL and testbench

Parametrised, pipelined Kogge-Stone add/subtract unit, the next generation of the combinational 32-bit KSA. Width and pipeline depth are configurable. It adds subtract, carry-in, status flags and a per-stage valid/ready handshake, so it drops into the datapath as a streaming arithmetic stage with back-pressure.

---
 rtl/ksa_pkg.sv | 20 ++
 rtl/ksa_prefix_level.sv | 28 ++
 rtl/ksa_pipe_alu.sv | 241 ++++++++++++++++++++++++
 tb/tb_ksa_pipe_alu.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone add/subtract unit.
package ksa_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBB = 2'd3
    } ksa_op_t;

    // Cycles from input acceptance to out_valid: the operand stage plus one
    // register per group of PIPE_EVERY prefix levels (the last group's
    // register is the output stage).
    function automatic int ksa_latency(input int width, input int pipe_every);
        int levels;
        levels = $clog2(width);
        return 1 + (levels + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level with span 2**LEVEL.
module ksa_prefix_level #(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);

    localparam int SPAN = 1 << LEVEL;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_bit
            if (gi >= SPAN) begin : gen_comb
                // Merge this bit's group with the group SPAN bits below.
                assign g_o[gi] = g_i[gi] | (p_i[gi] & g_i[gi-SPAN]);
                assign p_o[gi] = p_i[gi] & p_i[gi-SPAN];
            end else begin : gen_pass
                assign g_o[gi] = g_i[gi];
                assign p_o[gi] = p_i[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/ksa_pipe_alu.sv
// Pipelined Kogge-Stone add/subtract unit with flags and a valid/ready
// handshake at every register stage.
module ksa_pipe_alu
    import ksa_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG2W = $clog2(WIDTH);
    // Number of register stages ahead of the output stage.
    localparam int NG    = ksa_latency(WIDTH, PIPE_EVERY) - 1;

    // Operand / prefix stage registers (stage 0 holds the raw P/G).
    logic [NG-1:0]    vld_q, vld_d;
    logic [WIDTH-1:0] po_q  [NG];
    logic [WIDTH-1:0] po_d  [NG];
    logic [WIDTH-1:0] g_q   [NG];
    logic [WIDTH-1:0] g_d   [NG];
    logic [WIDTH-1:0] p_q   [NG];
    logic [WIDTH-1:0] p_d   [NG];
    logic [NG-1:0]    c0_q, c0_d;
    logic [TAG_W-1:0] tag_q [NG];
    logic [TAG_W-1:0] tag_d [NG];

    // Output stage registers.
    logic             ovld_q, ovld_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic [TAG_W-1:0] otag_q, otag_d;

    // Upstream view of each stage: index s is what feeds stage s,
    // index NG is what feeds the output stage.
    logic [NG:0]      up_vld;
    logic [NG:0]      up_c0;
    logic [WIDTH-1:0] up_po  [NG+1];
    logic [TAG_W-1:0] up_tag [NG+1];
    logic [WIDTH-1:0] stg_g_in [NG];
    logic [WIDTH-1:0] stg_p_in [NG];

    logic [NG:0]      rdy;
    logic             rdy_acc;

    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
    logic [WIDTH-1:0] p_in0;
    logic [WIDTH-1:0] g_in0;

    logic [WIDTH-1:0] fin_g;
    logic [WIDTH-1:0] unused_fin_p;
    logic [WIDTH:0]   fin_c;
    logic [WIDTH-1:0] fin_sum;

    // Effective carry-in for the selected operation.
    always_comb begin
        c0_in = 1'b0;
        case (ksa_op_t'(op))
            OP_ADD:  c0_in = 1'b0;
            OP_SUB:  c0_in = 1'b1;
            OP_ADC:  c0_in = cin;
            OP_SBB:  c0_in = cin;
            default: c0_in = 1'b0;
        endcase
    end

    // Bit 0 generate absorbs the carry-in so the prefix tree yields true carries.
    assign b_eff = op[0] ? ~b : b;
    assign p_in0 = a ^ b_eff;
    assign g_in0 = (a & b_eff) | {{(WIDTH-1){1'b0}}, p_in0[0] & c0_in};

    assign up_vld      = {vld_q, in_valid};
    assign up_c0       = {c0_q, c0_in};
    assign up_po[0]    = p_in0;
    assign up_tag[0]   = in_tag;
    assign stg_g_in[0] = g_in0;
    assign stg_p_in[0] = p_in0;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : gen_up
            assign up_po[gi+1]  = po_q[gi];
            assign up_tag[gi+1] = tag_q[gi];
        end

        for (gi = 0; gi < LOG2W; gi++) begin : gen_lvl
            logic [WIDTH-1:0] lg_i, lp_i, lg_o, lp_o;
            if (gi % PIPE_EVERY == 0) begin : gen_src_reg
                assign lg_i = g_q[gi / PIPE_EVERY];
                assign lp_i = p_q[gi / PIPE_EVERY];
            end else begin : gen_src_lvl
                assign lg_i = gen_lvl[gi-1].lg_o;
                assign lp_i = gen_lvl[gi-1].lp_o;
            end
            ksa_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (gi)
            ) u_level (
                .g_i (lg_i),
                .p_i (lp_i),
                .g_o (lg_o),
                .p_o (lp_o)
            );
        end

        for (gi = 1; gi < NG; gi++) begin : gen_stg_in
            assign stg_g_in[gi] = gen_lvl[gi*PIPE_EVERY-1].lg_o;
            assign stg_p_in[gi] = gen_lvl[gi*PIPE_EVERY-1].lp_o;
        end
    endgenerate

    // The group propagate of the last level has no consumer.
    assign fin_g        = gen_lvl[LOG2W-1].lg_o;
    assign unused_fin_p = gen_lvl[LOG2W-1].lp_o;
    assign fin_c        = {fin_g, up_c0[NG]};
    assign fin_sum      = up_po[NG] ^ fin_c[WIDTH-1:0];

    // Ready chain, flattened: a stage is ready if it or any stage after it
    // is empty, or the consumer takes the result.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready | ~ovld_q;
        rdy[NG] = rdy_acc;
        for (int s = NG - 1; s >= 0; s--) begin
            rdy_acc = rdy_acc | ~vld_q[s];
            rdy[s]  = rdy_acc;
        end
    end

    // Stage next-state: load on transfer, otherwise hold.
    always_comb begin
        vld_d = vld_q;
        c0_d  = c0_q;
        for (int s = 0; s < NG; s++) begin
            po_d[s]  = po_q[s];
            g_d[s]   = g_q[s];
            p_d[s]   = p_q[s];
            tag_d[s] = tag_q[s];
            if (rdy[s]) begin
                vld_d[s] = up_vld[s];
            end
            if (rdy[s] && up_vld[s]) begin
                po_d[s]  = up_po[s];
                g_d[s]   = stg_g_in[s];
                p_d[s]   = stg_p_in[s];
                c0_d[s]  = up_c0[s];
                tag_d[s] = up_tag[s];
            end
        end
    end

    // Output stage next-state: sum, flags and tag captured on transfer.
    always_comb begin
        ovld_d = ovld_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        otag_d = otag_q;
        if (rdy[NG]) begin
            ovld_d = up_vld[NG];
        end
        if (rdy[NG] && up_vld[NG]) begin
            sum_d  = fin_sum;
            cout_d = fin_c[WIDTH];
            ovf_d  = fin_c[WIDTH] ^ fin_c[WIDTH-1];
            zero_d = ~|fin_sum;
            neg_d  = fin_sum[WIDTH-1];
            otag_d = up_tag[NG];
        end
    end

    // State registers; reset empties the pipeline and clears the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            c0_q   <= '0;
            for (int s = 0; s < NG; s++) begin
                po_q[s]  <= '0;
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                tag_q[s] <= '0;
            end
            ovld_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            otag_q <= '0;
        end else begin
            vld_q  <= vld_d;
            c0_q   <= c0_d;
            for (int s = 0; s < NG; s++) begin
                po_q[s]  <= po_d[s];
                g_q[s]   <= g_d[s];
                p_q[s]   <= p_d[s];
                tag_q[s] <= tag_d[s];
            end
            ovld_q <= ovld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            otag_q <= otag_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = ovld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign out_tag   = otag_q;

endmodule

// File: tb/tb_ksa_pipe_alu.sv
// Directed and streaming checks for ksa_pipe_alu (32-bit/2 and 8-bit/1).
module tb_ksa_pipe_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32-bit instance, default pipelining.
    logic        in_valid, in_ready, out_valid, out_ready, cin;
    logic        cout, overflow, zero, negative;
    logic [31:0] a, b, sum;
    logic [1:0]  op;
    logic [3:0]  in_tag, out_tag;

    // 8-bit instance, one register per level.
    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8;
    logic        cout8, overflow8, zero8, negative8;
    logic [7:0]  a8, b8, sum8;
    logic [1:0]  op8;
    logic [3:0]  in_tag8, out_tag8;

    int checks = 0;
    int errors = 0;

    ksa_pipe_alu #(.WIDTH(32), .PIPE_EVERY(2), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow), .zero(zero), .negative(negative), .out_tag(out_tag)
    );

    ksa_pipe_alu #(.WIDTH(8), .PIPE_EVERY(1), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .cin(cin8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .overflow(overflow8), .zero(zero8), .negative(negative8), .out_tag(out_tag8)
    );

    // Behavioural reference: returns {ovf, neg, zero, cout, sum[31:0]} for width w.
    function automatic logic [35:0] model(input int w, input logic [1:0] m_op,
                                          input logic [31:0] m_a, input logic [31:0] m_b,
                                          input logic m_cin);
        logic [32:0] mask, t;
        logic [31:0] am, beff, s;
        logic        c0, co, ovf;
        mask = (33'h1 << w) - 33'h1;
        am   = m_a & mask[31:0];
        beff = (m_op[0] ? ~m_b : m_b) & mask[31:0];
        c0   = (m_op == 2'd0) ? 1'b0 : (m_op == 2'd1) ? 1'b1 : m_cin;
        t    = {1'b0, am} + {1'b0, beff} + {32'h0, c0};
        s    = t[31:0] & mask[31:0];
        co   = t[w];
        ovf  = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
        return {ovf, s[w-1], (s == 32'h0), co, s};
    endfunction

    // Drive one beat into the 32-bit unit and wait for its result.
    task automatic run_single32(input logic [1:0] t_op, input logic [31:0] t_a,
                                input logic [31:0] t_b, input logic t_cin,
                                input logic [3:0] t_tag, output int lat,
                                output logic [35:0] res, output logic [3:0] tag_o);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = t_op; a = t_a; b = t_b;
        cin = t_cin; in_tag = t_tag;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        res   = {overflow, negative, zero, cout, sum};
        tag_o = out_tag;
        $display("txn32 op=%0d a=%h b=%h cin=%0d tag=%0d -> lat=%0d sum=%h c=%0d v=%0d z=%0d n=%0d",
                 t_op, t_a, t_b, t_cin, t_tag, lat, sum, cout, overflow, zero, negative);
    endtask

    task automatic run_single8(input logic [1:0] t_op, input logic [7:0] t_a,
                               input logic [7:0] t_b, input logic t_cin,
                               input logic [3:0] t_tag, output int lat,
                               output logic [35:0] res, output logic [3:0] tag_o);
        int n;
        @(posedge clk); #1;
        out_ready8 = 1'b1; in_valid8 = 1'b1; op8 = t_op; a8 = t_a; b8 = t_b;
        cin8 = t_cin; in_tag8 = t_tag;
        #1;
        n = 0;
        while (!in_ready8 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        res   = {overflow8, negative8, zero8, cout8, 24'h0, sum8};
        tag_o = out_tag8;
        $display("txn8 op=%0d a=%h b=%h cin=%0d tag=%0d -> lat=%0d sum=%h c=%0d v=%0d z=%0d n=%0d",
                 t_op, t_a, t_b, t_cin, t_tag, lat, sum8, cout8, overflow8, zero8, negative8);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({sum, cout, overflow, zero, negative, out_tag} !== 40'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                               {sum, cout, overflow, zero, negative, out_tag});
        end
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++; $display("FAIL reset_dut8: got valid=%b ready=%b expected 0/1",
                               out_valid8, in_ready8);
        end
    endtask

    // Hand-computed vectors: expected = {ovf, neg, zero, cout, sum}.
    task automatic test_arith;
        logic [1:0]  v_op  [8];
        logic [31:0] v_a   [8];
        logic [31:0] v_b   [8];
        logic        v_cin [8];
        logic [35:0] v_exp [8];
        int          lat;
        logic [35:0] res;
        logic [3:0]  tg;
        v_op  = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        v_a   = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd10, 32'd1,
                  32'h8000_0000, 32'd1, 32'd0};
        v_b   = '{32'h1, 32'h1, 32'd7, 32'd3, 32'd2, 32'd1, 32'd1, 32'd0};
        v_cin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        v_exp = '{{4'b0011, 32'h0000_0000},
                  {4'b1100, 32'h8000_0000},
                  {4'b0100, 32'hFFFF_FFFE},
                  {4'b0001, 32'h0000_0006},
                  {4'b0000, 32'h0000_0004},
                  {4'b1001, 32'h7FFF_FFFF},
                  {4'b0000, 32'h0000_0002},
                  {4'b0011, 32'h0000_0000}};
        for (int i = 0; i < 8; i++) begin
            run_single32(v_op[i], v_a[i], v_b[i], v_cin[i], 4'(i + 1), lat, res, tg);
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL arith%0d_latency: got %0d expected 4", i, lat);
            end
            checks++;
            if (res !== v_exp[i]) begin
                errors++; $display("FAIL arith%0d_result: got %h expected %h", i, res, v_exp[i]);
            end
            checks++;
            if (tg !== 4'(i + 1)) begin
                errors++; $display("FAIL arith%0d_tag: got %0d expected %0d", i, tg, i + 1);
            end
        end
    endtask

    function automatic logic [31:0] beat_a(input int i);
        return 32'h0F0F_0F0F ^ (32'(i) * 32'h0101_0101);
    endfunction

    function automatic logic [31:0] beat_b(input int i);
        return 32'h0000_1000 * 32'(i) + 32'd7;
    endfunction

    // Ten beats back to back, consumer stalled for cycles 6..10.
    task automatic test_back_to_back;
        int          sent, rcvd, inflight;
        logic        prev_hold, saw_full;
        logic [39:0] prev_out, cur_out;
        logic [35:0] exp;
        @(posedge clk); #1;
        sent = 0; rcvd = 0; prev_hold = 1'b0; saw_full = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            in_valid  = (sent < 10);
            op        = 2'(sent % 4);
            a         = beat_a(sent);
            b         = beat_b(sent);
            cin       = sent[0];
            in_tag    = 4'(sent);
            #1;
            inflight = sent - rcvd;
            cur_out  = {out_valid, overflow, negative, zero, cout, sum, out_tag};
            if (prev_hold) begin
                checks++;
                if (cur_out !== prev_out) begin
                    errors++; $display("FAIL stall_stable: got %h expected %h", cur_out, prev_out);
                end
            end
            if (!in_ready) begin
                saw_full = 1'b1;
                checks++;
                if (inflight != 4) begin
                    errors++; $display("FAIL ready_low_inflight: got %0d expected 4", inflight);
                end
            end else if (inflight == 4 && out_ready) begin
                checks++;
                if (!out_valid) begin
                    errors++; $display("FAIL full_out_valid: got 0 expected 1");
                end
            end
            if (out_valid && out_ready) begin
                exp = model(32, 2'(rcvd % 4), beat_a(rcvd), beat_b(rcvd), rcvd[0]);
                $display("stream out tag=%0d sum=%h c=%0d v=%0d z=%0d n=%0d",
                         out_tag, sum, cout, overflow, zero, negative);
                checks++;
                if ({overflow, negative, zero, cout, sum} !== exp || out_tag !== 4'(rcvd)) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got tag=%0d res=%h expected tag=%0d res=%h",
                             rcvd, out_tag, {overflow, negative, zero, cout, sum}, rcvd, exp);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            prev_hold = out_valid && !out_ready;
            prev_out  = cur_out;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd != 10) begin
            errors++; $display("FAIL stream_count: got %0d expected 10", rcvd);
        end
        checks++;
        if (!saw_full) begin
            errors++; $display("FAIL stream_backpressure: in_ready never low, expected low");
        end
    endtask

    // Three beats in flight, one reset cycle, nothing stale afterwards.
    task automatic test_mid_reset;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = 2'd0; a = 32'h100 + 32'(i); b = 32'h1; cin = 1'b0;
            in_tag = 4'(10 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({sum, cout, overflow, zero, negative, out_tag} !== 40'h0) begin
            errors++; $display("FAIL midreset_outputs: got %h expected 0",
                               {sum, cout, overflow, zero, negative, out_tag});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_stale: got out_valid=%b tag=%0d expected 0",
                                   out_valid, out_tag);
            end
        end
    endtask

    // 8-bit, one level per stage: directed corners then a random stream.
    task automatic test_w8_random;
        int          lat, n;
        logic [35:0] res, exp;
        logic [3:0]  tg;
        logic [39:0] q[$];
        logic [39:0] head;
        run_single8(2'd2, 8'hFF, 8'h00, 1'b1, 4'd5, lat, res, tg);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL w8_adc_latency: got %0d expected 4", lat);
        end
        checks++;
        if (res !== {4'b0011, 32'h0} || tg !== 4'd5) begin
            errors++; $display("FAIL w8_adc_result: got %h tag %0d expected %h tag 5",
                               res, tg, {4'b0011, 32'h0});
        end
        run_single8(2'd0, 8'h7F, 8'h01, 1'b0, 4'd6, lat, res, tg);
        checks++;
        if (res !== {4'b1100, 32'h80}) begin
            errors++; $display("FAIL w8_add_ovf: got %h expected %h", res, {4'b1100, 32'h80});
        end
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid8  = ($urandom_range(3) != 0);
            out_ready8 = ($urandom_range(2) != 0);
            op8        = 2'($urandom_range(3));
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            cin8       = 1'($urandom_range(1));
            in_tag8    = 4'($urandom);
            #1;
            if (out_valid8 && out_ready8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL w8_rand_extra: got tag=%0d expected no beat", out_tag8);
                end else begin
                    head = q.pop_front();
                    if ({out_tag8, overflow8, negative8, zero8, cout8, 24'h0, sum8} !== head) begin
                        errors++;
                        $display("FAIL w8_rand_beat: got %h expected %h",
                                 {out_tag8, overflow8, negative8, zero8, cout8, 24'h0, sum8}, head);
                    end
                end
            end
            if (in_valid8 && in_ready8) begin
                exp = model(8, op8, {24'h0, a8}, {24'h0, b8}, cin8);
                q.push_back({in_tag8, exp});
                $display("rand8 in op=%0d a=%h b=%h cin=%0d tag=%0d", op8, a8, b8, cin8, in_tag8);
            end
            @(posedge clk); #1;
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            #1;
            if (out_valid8) begin
                head = q.pop_front();
                checks++;
                if ({out_tag8, overflow8, negative8, zero8, cout8, 24'h0, sum8} !== head) begin
                    errors++;
                    $display("FAIL w8_drain_beat: got %h expected %h",
                             {out_tag8, overflow8, negative8, zero8, cout8, 24'h0, sum8}, head);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL w8_drain_count: got %0d left expected 0", q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; cin = 1'b0; in_tag = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0; cin8 = 1'b0; in_tag8 = '0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_mid_reset();
        test_w8_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
